// File: rtl/cnt_seq_if.sv
// cnt_seq_if: control/status bundle between cnt_seq_ctrl and its surroundings, including the counter handshake.
interface cnt_seq_if #(parameter int PW = 4);
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [3:0]    pre;
  logic [PW-1:0] passes;
  logic          tc_in;
  logic          ce_out;
  logic          up_out;
  logic          L_out;
  logic [3:0]    di_out;
  logic          busy;
  logic          done;
  logic [PW-1:0] pass_cnt;
  modport master (output start, abort, mode, pre, passes, tc_in,
                  input ce_out, up_out, L_out, di_out, busy, done, pass_cnt);
  modport slave  (input start, abort, mode, pre, passes, tc_in,
                  output ce_out, up_out, L_out, di_out, busy, done, pass_cnt);
endinterface

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: preloads a 4-bit up/down counter, drives a prescaled ce tick train and counts terminal-count passes.
module cnt_seq_ctrl #(
  parameter int PRESC = 4,
  parameter int PW    = 4
) (
  input  logic     clk,
  input  logic     clr,
  cnt_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int PB = $clog2(PRESC);
  state_t        state;
  logic [PB-1:0] presc;
  logic          bounce, up, tick, hit;
  logic [3:0]    di;
  logic [PW-1:0] passes_r, cnt;
  assign tick = state == RUN && presc == PB'(PRESC - 1);
  assign hit  = tick && bus.tc_in;
  // abort gates ce in the very cycle it is raised; bounce suppresses the wrap at terminal count
  assign bus.ce_out   = !bus.abort && (state == LOAD || (tick && !(bounce && bus.tc_in)));
  assign bus.L_out    = state == LOAD;
  assign bus.busy     = state == LOAD || state == RUN;
  assign bus.done     = state == DONE;
  assign bus.up_out   = up;
  assign bus.di_out   = di;
  assign bus.pass_cnt = cnt;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state    <= IDLE;
      presc    <= '0;
      bounce   <= 1'b0;
      up       <= 1'b0;
      di       <= '0;
      passes_r <= '0;
      cnt      <= '0;
    end else
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          bounce   <= bus.mode == 2'b10;
          di       <= bus.pre;
          passes_r <= bus.passes;
          cnt      <= '0;
          if (bus.passes == '0) state <= DONE;
          else begin
            state <= LOAD;
            up    <= bus.mode != 2'b01;
          end
        end
        LOAD: begin
          presc <= '0;
          state <= bus.abort ? IDLE : RUN;
        end
        RUN: if (bus.abort) state <= IDLE;
        else begin
          presc <= tick ? '0 : presc + 1'b1;
          if (hit) begin
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
            if (bounce) up <= ~up;
            if (cnt + 1'b1 == passes_r) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule
